// File: rtl/util_diff_1553_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : util_diff_1553_pkg
//  Description : Shared definitions for the differential 1553 Manchester
//                decoder: FSM state encoding, line level constants and
//                sync-length derivation from the half-bit period.
//  Revision    : 1.0  initial release
// ============================================================================
package util_diff_1553_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC_A = 2'd1,
        ST_SYNC_B = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    // Line levels from the differential front end; 00/11 mean no signal.
    localparam logic [1:0] POS = 2'b10;
    localparam logic [1:0] NEG = 2'b01;

    // Bit index of the parity bit (16 data bits precede it).
    localparam logic [4:0] PARITY_BIT = 5'd16;

    // Each sync half lasts three half-bit periods.
    function automatic int sync_len(input int h);
        return 3 * h;
    endfunction

    function automatic int sync_min(input int h, input int tol);
        return 3 * h - tol;
    endfunction

    function automatic int sync_max(input int h, input int tol);
        return 3 * h + tol;
    endfunction

    function automatic logic is_level(input logic [1:0] lvl);
        return (lvl == POS) || (lvl == NEG);
    endfunction

    function automatic logic [1:0] opposite(input logic [1:0] lvl);
        return {lvl[0], lvl[1]};
    endfunction

endpackage : util_diff_1553_pkg
`default_nettype wire

// File: rtl/util_manchester_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : util_manchester_sampler
//  Description : Free-running timer referenced to the sync mid-point (t0).
//                Times out the second sync half, then produces mid-half
//                sample strobes and the current bit index for each bit.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - pulse on the t0 clock, loads the timer
//                active          - decoder is in SYNC_B/DATA; low clears
//                first_stb       - sample the first half of bit_idx now
//                second_stb      - sample the second half of bit_idx now
//                in_data         - second sync half has elapsed
//                bit_idx         - bit number being received (16 = parity)
//  Revision    : 1.0  initial release
// ============================================================================
module util_manchester_sampler
    import util_diff_1553_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       active,
    output logic       first_stb,
    output logic       second_stb,
    output logic       in_data,
    output logic [4:0] bit_idx
);

    localparam int c_sync_clks = sync_len(HALF_BIT_CLKS);
    localparam int c_sync_w    = $clog2(c_sync_clks);
    localparam int c_phase_w   = $clog2(2 * HALF_BIT_CLKS);

    localparam logic [c_sync_w-1:0]  c_sync_one   = c_sync_w'(1);
    localparam logic [c_sync_w-1:0]  c_sync_last  = c_sync_w'(c_sync_clks - 1);
    localparam logic [c_phase_w-1:0] c_phase_one  = c_phase_w'(1);
    localparam logic [c_phase_w-1:0] c_phase_last = c_phase_w'(2 * HALF_BIT_CLKS - 1);
    localparam logic [c_phase_w-1:0] c_first_at   = c_phase_w'(HALF_BIT_CLKS / 2);
    localparam logic [c_phase_w-1:0] c_second_at  = c_phase_w'((3 * HALF_BIT_CLKS) / 2);

    logic [c_sync_w-1:0]  r_sync_cnt;
    logic [c_phase_w-1:0] r_phase;
    logic [4:0]           r_bit;
    logic                 r_in_data;

    // Counter value n is held while the clock t0+n is sampled: start loads 1
    // on t0, so phase p of bit k lines up with clock t0+3H+2Hk+p.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_cnt <= '0;
            r_in_data  <= 1'b0;
            r_phase    <= '0;
            r_bit      <= '0;
        end else if (start) begin
            r_sync_cnt <= c_sync_one;
            r_in_data  <= 1'b0;
            r_phase    <= '0;
            r_bit      <= '0;
        end else if (!active) begin
            r_sync_cnt <= '0;
            r_in_data  <= 1'b0;
            r_phase    <= '0;
            r_bit      <= '0;
        end else if (!r_in_data) begin
            if (r_sync_cnt == c_sync_last) begin
                r_in_data <= 1'b1;
                r_phase   <= '0;
            end else begin
                r_sync_cnt <= r_sync_cnt + c_sync_one;
            end
        end else if (r_phase == c_phase_last) begin
            r_phase <= '0;
            r_bit   <= r_bit + 5'd1;
        end else begin
            r_phase <= r_phase + c_phase_one;
        end
    end

    assign first_stb  = r_in_data && (r_phase == c_first_at);
    assign second_stb = r_in_data && (r_phase == c_second_at);
    assign in_data    = r_in_data;
    assign bit_idx    = r_bit;

endmodule : util_manchester_sampler
`default_nettype wire

// File: rtl/util_diff_1553_dec.sv
`default_nettype none
// ============================================================================
//  Module      : util_diff_1553_dec
//  Description : MIL-STD-1553 style Manchester word decoder fed by a
//                differential level detector. Recognises the 3-bit-long
//                sync, then samples 16 data bits plus odd parity against a
//                timer started at the sync mid-point.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                en          - decoder enable (low forces IDLE, no pulses)
//                diff_in     - 10 positive, 01 negative, 00/11 no signal
//                data        - last good word, MSB received first
//                sync_type   - 1 command/status sync, 0 data sync
//                data_valid  - one-cycle pulse for a good word
//                parity_err  - odd-parity failure of the flagged word
//                frame_err   - one-cycle pulse on a Manchester violation
//                idle        - FSM is in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module util_diff_1553_dec
    import util_diff_1553_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 8,
    parameter int SYNC_TOL      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  diff_in,
    output logic [15:0] data,
    output logic        sync_type,
    output logic        data_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        idle
);

    localparam int c_run_max_i = sync_max(HALF_BIT_CLKS, SYNC_TOL);
    localparam int c_run_w     = $clog2(c_run_max_i + 1);

    localparam logic [c_run_w-1:0] c_run_one = c_run_w'(1);
    localparam logic [c_run_w-1:0] c_run_min = c_run_w'(sync_min(HALF_BIT_CLKS, SYNC_TOL));
    localparam logic [c_run_w-1:0] c_run_max = c_run_w'(c_run_max_i);

    state_t               r_state;
    logic [1:0]           r_prev;
    logic [1:0]           r_level;
    logic [c_run_w-1:0]   r_run_cnt;
    logic                 r_sync_type;
    logic [1:0]           r_h1;
    logic [1:0]           r_h2;
    logic                 r_eval;
    logic                 r_eval_last;
    logic [15:0]          r_shift;

    logic                 w_first_stb;
    logic                 w_second_stb;
    logic                 w_in_data;
    logic [4:0]           w_bit_idx;
    logic                 w_in_range;
    logic                 w_start;
    logic                 w_active;
    logic                 w_bit_ok;
    logic                 w_bit_val;

    assign w_in_range = (r_run_cnt >= c_run_min) && (r_run_cnt <= c_run_max);
    assign w_start    = en && (r_state == ST_SYNC_A) &&
                        (diff_in == opposite(r_level)) && w_in_range;
    assign w_active   = (r_state == ST_SYNC_B) || (r_state == ST_DATA);

    // A bit is legal only as POS->NEG (1) or NEG->POS (0).
    assign w_bit_ok   = ((r_h1 == POS) && (r_h2 == NEG)) ||
                        ((r_h1 == NEG) && (r_h2 == POS));
    assign w_bit_val  = (r_h1 == POS);

    assign idle       = (r_state == ST_IDLE);

    util_manchester_sampler #(
        .HALF_BIT_CLKS (HALF_BIT_CLKS)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .active     (w_active),
        .first_stb  (w_first_stb),
        .second_stb (w_second_stb),
        .in_data    (w_in_data),
        .bit_idx    (w_bit_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prev      <= 2'b00;
            r_level     <= 2'b00;
            r_run_cnt   <= '0;
            r_sync_type <= 1'b0;
            r_h1        <= 2'b00;
            r_h2        <= 2'b00;
            r_eval      <= 1'b0;
            r_eval_last <= 1'b0;
            r_shift     <= '0;
            data        <= '0;
            sync_type   <= 1'b0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_prev     <= diff_in;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (!en) begin
                r_state   <= ST_IDLE;
                r_run_cnt <= '0;
                r_eval    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Only an edge into a valid level can begin a sync.
                        if (is_level(diff_in) && (diff_in != r_prev)) begin
                            r_state   <= ST_SYNC_A;
                            r_level   <= diff_in;
                            r_run_cnt <= c_run_one;
                        end
                    end

                    ST_SYNC_A: begin
                        if (diff_in == r_level) begin
                            if (r_run_cnt >= c_run_max) begin
                                r_state   <= ST_IDLE;
                                r_run_cnt <= '0;
                            end else begin
                                r_run_cnt <= r_run_cnt + c_run_one;
                            end
                        end else if (w_start) begin
                            r_state     <= ST_SYNC_B;
                            r_sync_type <= (r_level == POS);
                            r_run_cnt   <= '0;
                            r_eval      <= 1'b0;
                            r_shift     <= '0;
                        end else begin
                            // No signal, or a mid-transition at the wrong time.
                            r_state   <= ST_IDLE;
                            r_run_cnt <= '0;
                        end
                    end

                    ST_SYNC_B: begin
                        if (w_in_data) begin
                            r_state <= ST_DATA;
                        end
                    end

                    ST_DATA: begin
                        if (w_first_stb) begin
                            r_h1 <= diff_in;
                        end
                        if (w_second_stb) begin
                            r_h2        <= diff_in;
                            r_eval      <= 1'b1;
                            r_eval_last <= (w_bit_idx == PARITY_BIT);
                        end
                        // Halves are judged one clock after the second sample.
                        if (r_eval) begin
                            r_eval <= 1'b0;
                            if (!w_bit_ok) begin
                                frame_err <= 1'b1;
                                r_state   <= ST_IDLE;
                            end else if (r_eval_last) begin
                                data       <= r_shift;
                                sync_type  <= r_sync_type;
                                parity_err <= ~(^r_shift ^ w_bit_val);
                                data_valid <= 1'b1;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_shift <= {r_shift[14:0], w_bit_val};
                            end
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : util_diff_1553_dec
`default_nettype wire

// File: tb/tb_util_diff_1553_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_util_diff_1553_dec
//  Description : Self-checking bench for util_diff_1553_dec. Frames are
//                described at word level (sync polarity, sync length, data,
//                parity, optional corrupted bit), expanded into a per-clock
//                line waveform, and the expected pulse time and contents are
//                derived from the frame timing rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_util_diff_1553_dec;

    localparam int H   = 8;
    localparam int TOL = 4;
    localparam logic [1:0] LV_POS = 2'b10;
    localparam logic [1:0] LV_NEG = 2'b01;

    typedef struct {
        int          cyc;
        logic [1:0]  kind;   // {data_valid, frame_err}
        logic [15:0] data;
        logic        st;
        logic        perr;
    } ev_t;

    logic        tb_data_clk = 1'b0;
    logic        rst         = 1'b1;
    logic        en          = 1'b1;
    logic [1:0]  diff_in     = 2'b00;
    logic [15:0] data;
    logic        sync_type;
    logic        data_valid;
    logic        parity_err;
    logic        frame_err;
    logic        idle;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  wave[$];
    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic        idle_q[$];
    logic [15:0] m_data = 16'h0000;
    logic        m_perr = 1'b0;

    always #5 tb_data_clk = ~tb_data_clk;

    util_diff_1553_dec #(
        .HALF_BIT_CLKS (H),
        .SYNC_TOL      (TOL)
    ) dut (
        .clk        (tb_data_clk),
        .rst        (rst),
        .en         (en),
        .diff_in    (diff_in),
        .data       (data),
        .sync_type  (sync_type),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .idle       (idle)
    );

    // Reference model: appends one frame to the waveform and its expected
    // outcome to exp_q. ck = corrupted bit (-1 none); ckind 0 both POS,
    // 1 both NEG, 2 first half no-signal, 3 second half no-signal.
    task automatic add_frame(input bit pos_first, input int l1, input logic [15:0] d,
                             input bit par, input int ck, input int ckind,
                             input int gap, output int t0);
        logic [1:0] a, b, h1, h2;
        logic       bv;
        ev_t        e;
        a = pos_first ? LV_POS : LV_NEG;
        b = pos_first ? LV_NEG : LV_POS;
        repeat (gap) wave.push_back(2'b00);
        repeat (l1) wave.push_back(a);
        t0 = wave.size();
        if (l1 > 3 * H + TOL) return;
        repeat (3 * H) wave.push_back(b);
        for (int k = 0; k < 17; k++) begin
            bv = (k < 16) ? d[15 - k] : par;
            h1 = bv ? LV_POS : LV_NEG;
            h2 = bv ? LV_NEG : LV_POS;
            if (k == ck) begin
                case (ckind)
                    0: begin h1 = LV_POS; h2 = LV_POS; end
                    1: begin h1 = LV_NEG; h2 = LV_NEG; end
                    2: h1 = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                    default: h2 = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                endcase
            end
            repeat (H) wave.push_back(h1);
            repeat (H) wave.push_back(h2);
            if (k == ck) begin
                e.cyc  = t0 + 3 * H + 2 * H * k + (3 * H) / 2 + 1;
                e.kind = 2'b01;
                e.data = m_data;
                e.st   = 1'b0;
                e.perr = m_perr;
                exp_q.push_back(e);
                return;
            end
        end
        e.cyc  = t0 + 3 * H + 2 * H * 16 + (3 * H) / 2 + 1;
        e.kind = 2'b10;
        e.data = d;
        e.st   = pos_first;
        e.perr = ~(^d ^ par);
        m_data = d;
        m_perr = e.perr;
        exp_q.push_back(e);
    endtask

    // Plays the waveform one level per clock and records every pulse.
    task automatic play(input int rst_at, input int en_from, input int en_to);
        ev_t e;
        obs_q.delete();
        idle_q.delete();
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge tb_data_clk);
            diff_in = wave[i];
            rst     = (i == rst_at);
            en      = !((i >= en_from) && (i < en_to));
            @(posedge tb_data_clk);
            #1;
            idle_q.push_back(idle);
            if (data_valid || frame_err) begin
                e.cyc  = i;
                e.kind = {data_valid, frame_err};
                e.data = data;
                e.st   = sync_type;
                e.perr = parity_err;
                obs_q.push_back(e);
            end
        end
        @(negedge tb_data_clk);
        diff_in = 2'b00;
        rst     = 1'b0;
        en      = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; diff_in = 2'b00;
        repeat (3) @(posedge tb_data_clk);
        #1;
        n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", data); end
        n_vec++; if (sync_type !== 1'b0) begin n_err++; $display("FAIL reset_sync_type: got %b want 0", sync_type); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
        @(negedge tb_data_clk);
        rst = 1'b0;
    endtask

    task automatic test_command_word;
        int t0;
        wave.delete(); exp_q.delete();
        add_frame(1'b1, 24, 16'h8001, 1'b1, -1, 0, 4, t0);
        repeat (8) wave.push_back(2'b00);
        play(-1, -1, -1);
        n_vec++;
        if (obs_q.size() != 1) begin
            n_err++; $display("FAIL cmd_count: got %0d pulses want 1", obs_q.size());
        end else begin
            n_vec++; if (obs_q[0].cyc != t0 + 293) begin n_err++; $display("FAIL cmd_time: got t0+%0d want t0+293", obs_q[0].cyc - t0); end
            n_vec++; if (obs_q[0].kind !== 2'b10) begin n_err++; $display("FAIL cmd_kind: got %b want 10", obs_q[0].kind); end
            n_vec++; if (obs_q[0].data !== 16'h8001) begin n_err++; $display("FAIL cmd_data: got %h want 8001", obs_q[0].data); end
            n_vec++; if (obs_q[0].st !== 1'b1) begin n_err++; $display("FAIL cmd_sync_type: got %b want 1", obs_q[0].st); end
            n_vec++; if (obs_q[0].perr !== 1'b0) begin n_err++; $display("FAIL cmd_parity_err: got %b want 0", obs_q[0].perr); end
        end
    endtask

    task automatic test_data_word;
        int t0;
        wave.delete(); exp_q.delete();
        add_frame(1'b0, 24, 16'h0000, 1'b0, -1, 0, 4, t0);
        repeat (8) wave.push_back(2'b00);
        play(-1, -1, -1);
        n_vec++;
        if (obs_q.size() != 1) begin
            n_err++; $display("FAIL dat_count: got %0d pulses want 1", obs_q.size());
        end else begin
            n_vec++; if (obs_q[0].kind !== 2'b10) begin n_err++; $display("FAIL dat_kind: got %b want 10", obs_q[0].kind); end
            n_vec++; if (obs_q[0].data !== 16'h0000) begin n_err++; $display("FAIL dat_data: got %h want 0000", obs_q[0].data); end
            n_vec++; if (obs_q[0].st !== 1'b0) begin n_err++; $display("FAIL dat_sync_type: got %b want 0", obs_q[0].st); end
            n_vec++; if (obs_q[0].perr !== 1'b1) begin n_err++; $display("FAIL dat_parity_err: got %b want 1", obs_q[0].perr); end
        end
    endtask

    task automatic test_long_sync;
        int          t0a, t0b;
        logic [15:0] d;
        d = 16'($urandom);
        wave.delete(); exp_q.delete();
        add_frame(1'b1, 30, 16'h1234, 1'b0, -1, 0, 4, t0a);
        add_frame(1'b1, 20, d, 1'b1, -1, 0, 3, t0b);
        repeat (8) wave.push_back(2'b00);
        play(-1, -1, -1);
        n_vec++; if (idle_q[t0a - 1] !== 1'b1) begin n_err++; $display("FAIL long_idle: got %b want 1", idle_q[t0a - 1]); end
        n_vec++;
        if (obs_q.size() != 1) begin
            n_err++; $display("FAIL long_count: got %0d pulses want 1", obs_q.size());
        end else begin
            n_vec++; if (obs_q[0].cyc != t0b + 293) begin n_err++; $display("FAIL short_ok_time: got t0+%0d want t0+293", obs_q[0].cyc - t0b); end
            n_vec++; if (obs_q[0].data !== d) begin n_err++; $display("FAIL short_ok_data: got %h want %h", obs_q[0].data, d); end
        end
    endtask

    task automatic test_frame_err;
        int          t0;
        logic [15:0] prev;
        prev = m_data;
        wave.delete(); exp_q.delete();
        add_frame(1'b1, 24, 16'($urandom), 1'($urandom), 5, 0, 4, t0);
        repeat (8) wave.push_back(2'b00);
        play(-1, -1, -1);
        n_vec++; if (idle_q[t0 + 116] !== 1'b0) begin n_err++; $display("FAIL ferr_busy: idle got %b want 0", idle_q[t0 + 116]); end
        n_vec++; if (idle_q[t0 + 118] !== 1'b1) begin n_err++; $display("FAIL ferr_idle: got %b want 1", idle_q[t0 + 118]); end
        n_vec++;
        if (obs_q.size() != 1) begin
            n_err++; $display("FAIL ferr_count: got %0d pulses want 1", obs_q.size());
        end else begin
            n_vec++; if (obs_q[0].cyc != t0 + 117) begin n_err++; $display("FAIL ferr_time: got t0+%0d want t0+117", obs_q[0].cyc - t0); end
            n_vec++; if (obs_q[0].kind !== 2'b01) begin n_err++; $display("FAIL ferr_kind: got %b want 01", obs_q[0].kind); end
            n_vec++; if (obs_q[0].data !== prev) begin n_err++; $display("FAIL ferr_data_hold: got %h want %h", obs_q[0].data, prev); end
        end
    endtask

    // Random mix of good, corrupted and over-long-sync frames, with every
    // other frame separated from the previous one by a single idle clock.
    task automatic test_back_to_back;
        int t0, r, l1, ck, ckind, gap, n;
        wave.delete(); exp_q.delete();
        for (int f = 0; f < 24; f++) begin
            r     = int'($urandom_range(0, 9));
            gap   = (f % 2 == 1) ? 1 : int'($urandom_range(2, 5));
            l1    = int'($urandom_range(3 * H - TOL, 3 * H + TOL));
            ck    = -1;
            ckind = 0;
            if (r < 2) begin
                l1 = int'($urandom_range(3 * H + TOL + 1, 3 * H + TOL + 6));
            end else if (r < 4) begin
                ck    = int'($urandom_range(0, 16));
                ckind = int'($urandom_range(0, 3));
            end
            add_frame(1'($urandom), l1, 16'($urandom), 1'($urandom), ck, ckind, gap, t0);
        end
        repeat (8) wave.push_back(2'b00);
        play(-1, -1, -1);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rand_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if ((obs_q[i].cyc != exp_q[i].cyc) || (obs_q[i].kind !== exp_q[i].kind) ||
                (obs_q[i].data !== exp_q[i].data) || (obs_q[i].perr !== exp_q[i].perr) ||
                ((exp_q[i].kind == 2'b10) && (obs_q[i].st !== exp_q[i].st))) begin
                n_err++;
                $display("FAIL rand_ev%0d: got cyc=%0d kind=%b data=%h st=%b perr=%b want cyc=%0d kind=%b data=%h st=%b perr=%b",
                         i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, obs_q[i].st, obs_q[i].perr,
                         exp_q[i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].st, exp_q[i].perr);
            end
        end
    endtask

    task automatic test_en_low;
        int          t0a, t0b, en_from;
        logic [15:0] d;
        d = 16'($urandom) | 16'h0100;
        wave.delete(); exp_q.delete();
        add_frame(1'b1, 24, d, 1'b0, -1, 0, 4, t0a);
        add_frame(1'b0, 24, ~d, 1'b1, -1, 0, 4, t0b);
        en_from = t0b + 3 * H + 2 * H * 3 + 4;
        repeat (8) wave.push_back(2'b00);
        play(-1, en_from, wave.size());
        n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL en_count: got %0d pulses want 1", obs_q.size()); end
        n_vec++; if (idle_q[en_from] !== 1'b1) begin n_err++; $display("FAIL en_idle: got %b want 1", idle_q[en_from]); end
        n_vec++; if (data !== d) begin n_err++; $display("FAIL en_data_hold: got %h want %h", data, d); end
        n_vec++; if (sync_type !== 1'b1) begin n_err++; $display("FAIL en_sync_hold: got %b want 1", sync_type); end
        m_data = d;
    endtask

    task automatic test_rst_mid_frame;
        int t0, rst_at;
        wave.delete(); exp_q.delete();
        add_frame(1'b1, 24, 16'($urandom), 1'($urandom), -1, 0, 4, t0);
        rst_at = t0 + 3 * H + 2 * H * 9 + 4;
        repeat (8) wave.push_back(2'b00);
        play(rst_at, -1, -1);
        m_data = 16'h0000;
        m_perr = 1'b0;
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rst_count: got %0d pulses want 0", obs_q.size()); end
        n_vec++; if (idle_q[rst_at] !== 1'b1) begin n_err++; $display("FAIL rst_idle_same_edge: got %b want 1", idle_q[rst_at]); end
        n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL rst_data: got %h want 0000", data); end
        n_vec++; if (sync_type !== 1'b0) begin n_err++; $display("FAIL rst_sync_type: got %b want 0", sync_type); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL rst_parity_err: got %b want 0", parity_err); end
    endtask

    initial begin
        test_reset();
        test_command_word();
        test_data_word();
        test_long_sync();
        test_frame_err();
        test_back_to_back();
        test_en_low();
        test_rst_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_util_diff_1553_dec
`default_nettype wire
